// File: rtl/seq_tx_pkg.sv
// Shared types for the serial pattern transmitter.
// Holds the FSM state encoding and the captured config word.
package seq_tx_pkg;

    localparam int TX_PAT_W = 8;
    localparam int TX_CNT_W = 8;
    localparam int TX_GAP_W = 4;
    localparam int TX_LEN_W = $clog2(TX_PAT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [TX_PAT_W-1:0] pattern;
        logic [TX_LEN_W-1:0] len_m1;
        logic [TX_CNT_W-1:0] repeat_m1;
        logic [TX_GAP_W-1:0] gap;
        logic                idle_level;
    } cfg_t;

    // Lengths beyond the pattern register fall back to the full width.
    function automatic logic [TX_LEN_W-1:0] clamp_len(
        input logic [TX_LEN_W-1:0] len
    );
        if (int'(len) >= TX_PAT_W)
            return TX_LEN_W'(TX_PAT_W - 1);
        return len;
    endfunction

endpackage

// File: rtl/seq_tx_downcnt.sv
// Loadable down-counter with a zero flag.
// Load wins over decrement; the count holds at zero.
module seq_tx_downcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && !zero)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first,
// repeating it with optional idle gaps, then pulses done.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = TX_PAT_W,
    parameter int CNT_W = TX_CNT_W,
    parameter int GAP_W = TX_GAP_W,
    parameter int LEN_W = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len_m1,
    input  logic [CNT_W-1:0] repeat_m1,
    input  logic [GAP_W-1:0] gap,
    input  logic             idle_level,
    input  logic             abort,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    state_t state_q, state_d;
    cfg_t   cfg_q, cfg_d;

    logic [CNT_W-1:0] rep_q;
    logic             rep_clr, rep_inc;
    logic             cfg_load;
    logic             accept;

    logic [LEN_W-1:0] idx, idx_val;
    logic             idx_load, idx_dec, idx_zero;
    logic [GAP_W-1:0] gcnt, g_val;
    logic             g_load, g_dec, g_zero;

    assign accept = start_valid && start_ready;

    assign cfg_d = '{
        pattern:    pattern,
        len_m1:     clamp_len(len_m1),
        repeat_m1:  repeat_m1,
        gap:        gap,
        idle_level: idle_level
    };

    seq_tx_downcnt #(.W(LEN_W)) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .load_val (idx_val),
        .dec      (idx_dec),
        .count    (idx),
        .zero     (idx_zero)
    );

    seq_tx_downcnt #(.W(GAP_W)) u_gcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (g_load),
        .load_val (g_val),
        .dec      (g_dec),
        .count    (gcnt),
        .zero     (g_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_load)
                cfg_q <= cfg_d;
            if (rep_clr)
                rep_q <= '0;
            else if (rep_inc)
                rep_q <= rep_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cfg_load = 1'b0;
        rep_clr  = 1'b0;
        rep_inc  = 1'b0;
        idx_load = 1'b0;
        idx_val  = cfg_q.len_m1;
        idx_dec  = 1'b0;
        g_load   = 1'b0;
        g_val    = cfg_q.gap - 1'b1;
        g_dec    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cfg_load = 1'b1;
                    rep_clr  = 1'b1;
                    idx_load = 1'b1;
                    idx_val  = cfg_d.len_m1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!idx_zero) begin
                    idx_dec = 1'b1;
                end else if (rep_q == cfg_q.repeat_m1) begin
                    state_d = DONE;
                end else if (cfg_q.gap != '0) begin
                    rep_inc = 1'b1;
                    g_load  = 1'b1;
                    state_d = GAP;
                end else begin
                    rep_inc  = 1'b1;
                    idx_load = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (g_zero) begin
                    idx_load = 1'b1;
                    state_d  = SEND;
                end else begin
                    g_dec = |gcnt;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line outputs come straight from registered state and config.
    assign bit_valid   = (state_q == SEND);
    assign bit_out     = bit_valid ? cfg_q.pattern[idx] : cfg_q.idle_level;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign start_ready = (state_q == IDLE) && !rst;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx against a queue-based
// model of the expected line activity.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] pattern;
    logic [2:0] len_m1;
    logic [7:0] repeat_m1;
    logic [3:0] gap;
    logic       idle_level;
    logic       abort;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    seq_pattern_tx dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .len_m1      (len_m1),
        .repeat_m1   (repeat_m1),
        .gap         (gap),
        .idle_level  (idle_level),
        .abort       (abort),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] p, input int l, input int r,
                           input int g, input logic idl);
        pattern    = p;
        len_m1     = 3'(l);
        repeat_m1  = 8'(r);
        gap        = 4'(g);
        idle_level = idl;
    endtask

    task automatic junk_inputs();
        pattern    = 8'($urandom);
        len_m1     = 3'($urandom);
        repeat_m1  = 8'($urandom);
        gap        = 4'($urandom);
        idle_level = 1'($urandom);
    endtask

    // Drive a config, confirm it is accepted, leave inputs scrambled.
    task automatic start(input logic [7:0] p, input int l, input int r,
                         input int g, input logic idl);
        set_cfg(p, l, r, g, idl);
        start_valid = 1'b1;
        chk("accept_ready", start_ready, 1);
        step();
        start_valid = 1'b0;
        junk_inputs();
    endtask

    // Called on the first cycle after acceptance; returns on the
    // IDLE cycle after done.
    task automatic expect_stream(input logic [7:0] p, input int l,
                                 input int r, input int g,
                                 input logic idl);
        logic [1:0] q[$];
        for (int rr = 0; rr <= r; rr++) begin
            for (int i = l; i >= 0; i--)
                q.push_back({p[i], 1'b1});
            if (rr < r)
                for (int k = 0; k < g; k++)
                    q.push_back({idl, 1'b0});
        end
        foreach (q[k]) begin
            chk("bit_out", bit_out, q[k][1]);
            chk("bit_valid", bit_valid, q[k][0]);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("ready_busy", start_ready, 0);
            step();
        end
        chk("done_pulse", done, 1);
        chk("done_valid", bit_valid, 0);
        chk("done_line", bit_out, idl);
        chk("done_ready", start_ready, 0);
        step();
        chk("post_ready", start_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        abort       = 1'b0;
        set_cfg(8'h00, 0, 0, 0, 1'b0);
        step();
        step();
        chk("rst_bit", bit_out, 0);
        chk("rst_valid", bit_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", start_ready, 0);
        rst = 1'b0;
        step();
        chk("rel_ready", start_ready, 1);

        // single pattern
        start(8'h0B, 3, 0, 0, 1'b0);
        expect_stream(8'h0B, 3, 0, 0, 1'b0);

        // repeats with gap
        start(8'h03, 1, 2, 2, 1'b0);
        expect_stream(8'h03, 1, 2, 2, 1'b0);

        // back-to-back repeats
        start(8'h01, 0, 4, 0, 1'b0);
        expect_stream(8'h01, 0, 4, 0, 1'b0);

        // abort on the third bit
        start(8'h0B, 3, 0, 0, 1'b0);
        step();
        step();
        chk("abort_bit3", bit_out, 1);
        chk("abort_valid3", bit_valid, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", bit_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", start_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("abort_nodone", done, 0);
            step();
        end

        // reset during the first gap
        start(8'h03, 1, 2, 2, 1'b0);
        step();
        step();
        chk("gap_valid", bit_valid, 0);
        chk("gap_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_bit", bit_out, 0);
        chk("mid_rst_valid", bit_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", start_ready, 0);
        rst = 1'b0;
        step();
        chk("mid_rel_ready", start_ready, 1);
        start(8'hC5, 7, 1, 1, 1'b1);
        expect_stream(8'hC5, 7, 1, 1, 1'b1);

        // back-pressure: second config waits for IDLE
        set_cfg(8'hA5, 7, 0, 0, 1'b0);
        start_valid = 1'b1;
        step();
        set_cfg(8'h01, 7, 0, 0, 1'b1);
        expect_stream(8'hA5, 7, 0, 0, 1'b0);
        step();
        start_valid = 1'b0;
        expect_stream(8'h01, 7, 0, 0, 1'b1);

        // maximum repeat count must not wrap
        start(8'h01, 0, 255, 0, 1'b0);
        expect_stream(8'h01, 0, 255, 0, 1'b0);

        // randomized transfers
        for (int n = 0; n < 12; n++) begin
            logic [7:0] p;
            int         l, r, g;
            logic       idl;
            p   = 8'($urandom);
            l   = $urandom_range(0, 7);
            r   = $urandom_range(0, 5);
            g   = $urandom_range(0, 3);
            idl = 1'($urandom);
            start(p, l, r, g, idl);
            expect_stream(p, l, r, g, idl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
